// File: rtl/bin_to_bcd_display.sv
// Sequential binary-to-BCD converter (shift-add-3) feeding a 3-digit
// multiplexed common-anode 7-segment display with leading-zero blanking.
module bin_to_bcd_display #(
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  din,
  input  logic        load,
  output logic        busy,
  output logic        bcd_valid,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int             RW           = $clog2(REFRESH_CYCLES);
  localparam logic [RW-1:0]  REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_CONV = 1'b1;

  logic          r_state;
  logic [19:0]   r_shift;
  logic [2:0]    r_iter;
  logic [11:0]   r_bcd;
  logic          r_valid;
  logic [RW-1:0] r_refresh;
  logic [1:0]    r_idx;

  logic [19:0]   w_adj;
  logic [19:0]   w_shifted;
  logic [3:0]    w_nibble;
  logic          w_blank;
  logic [6:0]    w_glyph;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // All BCD nibbles are corrected in parallel before the shift.
  always_comb begin
    w_adj     = {add3(r_shift[19:16]), add3(r_shift[15:12]),
                 add3(r_shift[11:8]), r_shift[7:0]};
    w_shifted = {w_adj[18:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_iter  <= '0;
      r_bcd   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_shift <= {12'b0, din};
            r_iter  <= '0;
            r_state <= ST_CONV;
          end
        end
        default: begin
          r_shift <= w_shifted;
          r_iter  <= r_iter + 3'd1;
          if (r_iter == 3'd7) begin
            r_bcd   <= w_shifted[19:8];
            r_valid <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Scan runs free of the converter so the display never stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh <= '0;
      r_idx     <= '0;
    end else if (r_refresh == REFRESH_LAST) begin
      r_refresh <= '0;
      r_idx     <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    end else begin
      r_refresh <= r_refresh + RW'(1);
    end
  end

  always_comb begin
    w_nibble = r_bcd[3:0];
    w_blank  = 1'b0;
    case (r_idx)
      2'd1: begin
        w_nibble = r_bcd[7:4];
        w_blank  = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
      end
      2'd2: begin
        w_nibble = r_bcd[11:8];
        w_blank  = (r_bcd[11:8] == 4'd0);
      end
      default: begin
        w_nibble = r_bcd[3:0];
        w_blank  = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_glyph = 7'b1111111;
    case (w_nibble)
      4'd0: w_glyph = 7'b1000000;
      4'd1: w_glyph = 7'b1111001;
      4'd2: w_glyph = 7'b0100100;
      4'd3: w_glyph = 7'b0110000;
      4'd4: w_glyph = 7'b0011001;
      4'd5: w_glyph = 7'b0010010;
      4'd6: w_glyph = 7'b0000010;
      4'd7: w_glyph = 7'b1111000;
      4'd8: w_glyph = 7'b0000000;
      4'd9: w_glyph = 7'b0010000;
      default: w_glyph = 7'b1111111;
    endcase
  end

  assign busy      = (r_state == ST_CONV);
  assign bcd_valid = r_valid;
  assign bcd       = r_bcd;
  assign seg       = w_blank ? 7'b1111111 : w_glyph;
  assign an        = ~(3'b001 << r_idx);

endmodule

// File: doc/bin_to_bcd_display.md
Name: bin_to_bcd_display

Overview:
- Downstream stage of the 8-bit up/down counter: consumes its 8-bit count (Qout) and drives a 3-digit multiplexed common-anode 7-segment display.
- Converts binary to BCD sequentially using shift-add-3 (double dabble), holds the last completed result, and time-multiplexes the digits with leading-zero blanking.
- Display always shows the last completed conversion, so a conversion in progress never tears the display.

Parameters:
- REFRESH_CYCLES, default 50000: clk cycles each digit stays lit; minimum 2; refresh counter width is $clog2(REFRESH_CYCLES).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  8  binary value to convert (counter Qout).
- load  input  1  start-conversion request; sampled only in IDLE.
- busy  output  1  high while conversion in progress.
- bcd_valid  output  1  one-cycle pulse when bcd updates.
- bcd  output  12  {hundreds, tens, units} BCD nibbles of the last completed conversion.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- an  output  3  digit enables, active-low; an[0]=units, an[1]=tens, an[2]=hundreds.

Behaviour:
- Reset (synchronous, overrides everything) sets:
  - state=IDLE, busy=0, bcd_valid=0, bcd=12'h000;
  - shift register and iteration count cleared;
  - refresh counter=0, digit index=0;
  - so an=3'b110, seg=7'b1000000 (shows "  0").
- FSM states are IDLE and CONV.
- IDLE:
  - load=1 at edge k: shift reg <= {12'b0, din}, iter <= 0, state <= CONV.
  - busy is high from after edge k.
- CONV, each edge:
  - every BCD nibble >= 5 gets +3 (all nibbles in parallel, evaluated before the shift);
  - then the 20-bit register shifts left by 1 and iter increments.
- Edge k+8 (8th shift):
  - bcd <= upper 12 bits of the shifted result;
  - bcd_valid <= 1 for exactly one cycle;
  - state <= IDLE; busy <= 0.
- Latency: load edge to bcd_valid high is 8 clocks.
- load while busy is ignored; it is not queued.
- load in the cycle bcd_valid is high (state already IDLE) is accepted.
- din is captured only at the load edge; later din changes do not affect a running conversion.
- Reset mid-conversion aborts it: bcd=0, no bcd_valid pulse.
- Every din value 0..255 must produce an exact BCD result; max is 12'h255.
- Digit scan:
  - refresh counter counts 0..REFRESH_CYCLES-1 and wraps;
  - on wrap, digit index advances 0→1→2→0;
  - scan runs continuously, independent of the FSM.
- an = ~(3'b001 << idx).
- seg is a combinational decode of the registered idx and bcd.
- Decode table (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - nibble >9 (unreachable) = 1111111.
- Leading-zero blanking (seg=1111111 while that digit is selected):
  - hundreds blanked if hundreds==0;
  - tens blanked if hundreds==0 and tens==0;
  - units never blanked.
- A bcd update mid-scan takes effect immediately on the currently selected digit; the refresh counter is not disturbed.

Test Plan:
1. Assert reset 2 cycles -> busy=0, bcd_valid=0, bcd=12'h000, an=3'b110, seg=7'b1000000; hold 3×REFRESH_CYCLES -> an cycles 110,101,011, seg 1000000 then blank, blank.
2. Load din=8'd255 -> busy high exactly 8 cycles, bcd_valid one-cycle pulse 8 clocks after the load edge, bcd=12'h255; then load din=8'd0 in the bcd_valid cycle -> accepted, bcd=12'h000 eight clocks later.
3. REFRESH_CYCLES=4, load din=8'd7 -> bcd=12'h007; an=110/seg=1111000 for 4 cycles, then an=101/seg=1111111, then an=011/seg=1111111, repeating.
4. Load din=8'd105 -> bcd=12'h105; tens digit not blanked (an=101 shows seg=1000000), hundreds shows 1111001.
5. Load din=8'd200, then load din=8'd50 at the 3rd busy cycle -> single bcd_valid pulse, bcd=12'h200, no second conversion.
6. Load din=8'd99, then assert reset at the 4th busy cycle -> busy=0, bcd=12'h000, no bcd_valid pulse; a fresh load of 99 afterwards yields bcd=12'h099. Also sweep din 0..255 against a reference model for exact BCD.
